// File: rtl/dffrs_pkg.sv
// rtl/dffrs_pkg.sv - shared defaults and clear/preset control encoding for the dffrs flop bank
//
// Contents:
//   DEFAULT_WIDTH : default number of bits in a dffrs_x2 bank
//   DEFAULT_RST_Q : default value loaded into Q by the synchronous reset
//   ctrl_e        : {rn, sn} control pair decoded by dffrs_bit
package dffrs_pkg;

    localparam int   DEFAULT_WIDTH = 1;
    localparam logic DEFAULT_RST_Q = 1'b0;

    // The encoding is the raw {rn, sn} pair. Both controls are active-low,
    // so 2'b00 means clear and preset are requested together.
    typedef enum logic [1:0] {
        CLR_PRE_BOTH = 2'b00,
        CLR          = 2'b01,
        PRE          = 2'b10,
        LOAD         = 2'b11
    } ctrl_e;

    function automatic ctrl_e decode_ctrl(input logic rn, input logic sn);
        return ctrl_e'({rn, sn});
    endfunction

endpackage

// File: rtl/dffrs_bit.sv
// rtl/dffrs_bit.sv - single-bit D flop with synchronous clear, preset and reset
//
// Ports:
//   clk : clock, all updates on the rising edge
//   rst : synchronous reset, active-high, loads q=RST_Q / qn=~RST_Q
//   d   : data captured when rn and sn are both high
//   rn  : synchronous clear, active-low
//   sn  : synchronous preset, active-low
//   q   : registered true output
//   qn  : registered complementary output (independent register)
module dffrs_bit
    import dffrs_pkg::*;
#(
    parameter logic RST_Q = DEFAULT_RST_Q
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic rn,
    input  logic sn,
    output logic q,
    output logic qn
);

    ctrl_e ctrl;

    assign ctrl = decode_ctrl(rn, sn);

    // q and qn are kept as two flops on purpose: the clear/preset conflict
    // drives both high, which a single flop plus inverter cannot represent.
    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= RST_Q;
            qn <= ~RST_Q;
        end else begin
            case (ctrl)
                CLR_PRE_BOTH: begin
                    q  <= 1'b1;
                    qn <= 1'b1;
                end
                CLR: begin
                    q  <= 1'b0;
                    qn <= 1'b1;
                end
                PRE: begin
                    q  <= 1'b1;
                    qn <= 1'b0;
                end
                default: begin
                    q  <= d;
                    qn <= ~d;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Outputs must be complementary after any edge that was a reset or a
    // plain load; only the conflict, clear and preset edges are exempt from
    // the load rule, and clear/preset are complementary by construction.
    logic compl_expected;

    always_ff @(posedge clk) begin
        compl_expected <= rst | (rn & sn);
    end

    always @(posedge clk) begin
        if (compl_expected) begin
            assert (qn == ~q)
                else $error("dffrs_bit: qn is not the complement of q");
        end
    end
`endif

endmodule

// File: rtl/dffrs_x2.sv
// rtl/dffrs_x2.sv - bank of WIDTH independent D flops with clear, preset and reset
//
// Ports:
//   clk : clock, all updates on the rising edge
//   rst : synchronous reset, active-high, applied to every bit
//   d   : per-bit data
//   rn  : per-bit synchronous clear, active-low
//   sn  : per-bit synchronous preset, active-low
//   q   : registered true outputs
//   qn  : registered complementary outputs
module dffrs_x2
    import dffrs_pkg::*;
#(
    parameter int   WIDTH = DEFAULT_WIDTH,
    parameter logic RST_Q = DEFAULT_RST_Q
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] rn,
    input  logic [WIDTH-1:0] sn,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dffrs_bit #(
            .RST_Q (RST_Q)
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .d   (d[i]),
            .rn  (rn[i]),
            .sn  (sn[i]),
            .q   (q[i]),
            .qn  (qn[i])
        );
    end

endmodule

// File: tb/tb_dffrs_x2.sv
// tb/tb_dffrs_x2.sv - scoreboard bench for dffrs_x2 (1-bit banks with both reset values, 4-bit bank)
module tb_dffrs_x2;
    import dffrs_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_s, rn_s, sn_s;
    logic [3:0] d_w, rn_w, sn_w;
    logic       q_a, qn_a, q_b, qn_b;
    logic [3:0] q_w, qn_w;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [1:0] a;
        logic [1:0] b;
        logic [7:0] w;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    always #5 clk = ~clk;

    dffrs_x2 #(.WIDTH(1), .RST_Q(1'b0)) u_dut_a (
        .clk (clk), .rst (rst), .d (d_s), .rn (rn_s), .sn (sn_s), .q (q_a), .qn (qn_a)
    );

    dffrs_x2 #(.WIDTH(1), .RST_Q(1'b1)) u_dut_b (
        .clk (clk), .rst (rst), .d (d_s), .rn (rn_s), .sn (sn_s), .q (q_b), .qn (qn_b)
    );

    dffrs_x2 #(.WIDTH(4), .RST_Q(1'b0)) u_dut_w (
        .clk (clk), .rst (rst), .d (d_w), .rn (rn_w), .sn (sn_w), .q (q_w), .qn (qn_w)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Returns {q, qn} for one bit after a rising edge.
    function automatic logic [1:0] model_bit(input logic r, input logic rq,
                                             input logic d, input logic rn, input logic sn);
        if (r)           return {rq, ~rq};
        if (!rn && !sn)  return 2'b11;
        if (!rn)         return 2'b01;
        if (!sn)         return 2'b10;
        return {d, ~d};
    endfunction

    task automatic step(input string tag, input logic r,
                        input logic d1, input logic rn1, input logic sn1,
                        input logic [3:0] dw, input logic [3:0] rnw, input logic [3:0] snw);
        exp_t e;
        exp_t g;
        logic [1:0] bq;
        @(negedge clk);
        rst = r; d_s = d1; rn_s = rn1; sn_s = sn1;
        d_w = dw; rn_w = rnw; sn_w = snw;
        e.tag = tag;
        e.a = model_bit(r, 1'b0, d1, rn1, sn1);
        e.b = model_bit(r, 1'b1, d1, rn1, sn1);
        e.w = 8'h00;
        for (int i = 0; i < 4; i++) begin
            bq = model_bit(r, 1'b0, dw[i], rnw[i], snw[i]);
            e.w[4+i] = bq[1];
            e.w[i]   = bq[0];
        end
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check_eq({g.tag, "/a"}, {6'b0, q_a, qn_a}, {6'b0, g.a});
        check_eq({g.tag, "/b"}, {6'b0, q_b, qn_b}, {6'b0, g.b});
        check_eq({g.tag, "/w"}, {q_w, qn_w}, g.w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] c;
        logic [2:0] r3;
        d_s = 1'b0; rn_s = 1'b1; sn_s = 1'b1;
        d_w = 4'h0; rn_w = 4'hf; sn_w = 4'hf;

        // Reset values, then reset winning over a clear/preset conflict.
        step("rst_plain",    1'b1, 1'b1, 1'b1, 1'b1, 4'hf, 4'hf, 4'hf);
        step("rst_conflict", 1'b1, 1'b1, 1'b0, 1'b0, 4'hf, 4'h0, 4'h0);

        // Exhaustive {d, rn, sn} sweep, same controls on every wide bit.
        for (int k = 0; k < 8; k++) begin
            logic dk;
            dk = k[2];
            c  = LOAD;
            c  = k[1:0];
            step($sformatf("sweep_%0d", k), 1'b0, dk, c[1], c[0],
                 {4{dk}}, {4{c[1]}}, {4{c[0]}});
        end

        // Hold: inputs change while clk is low, outputs must not move.
        step("hold_pre", 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 4'hf, 4'hf);
        @(negedge clk);
        d_s = 1'b0; rn_s = 1'b0; sn_s = 1'b1;
        d_w = 4'ha; rn_w = 4'h0; sn_w = 4'h3;
        #3;
        check_eq("hold/a", {6'b0, q_a, qn_a}, {6'b0, last_exp.a});
        check_eq("hold/b", {6'b0, q_b, qn_b}, {6'b0, last_exp.b});
        check_eq("hold/w", {q_w, qn_w}, last_exp.w);

        // Conflict entry and exit.
        step("conflict_in",  1'b0, 1'b1, 1'b0, 1'b0, 4'hf, 4'h0, 4'h0);
        step("conflict_out", 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'hf, 4'hf);

        // Per-bit independence on the wide bank.
        step("indep", 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 4'b1110, 4'b1101);

        // Reset mid-stream then resume loading.
        step("mid_load",  1'b0, 1'b1, 1'b1, 1'b1, 4'hf, 4'hf, 4'hf);
        step("mid_rst",   1'b1, 1'b1, 1'b1, 1'b1, 4'hf, 4'hf, 4'hf);
        step("mid_after", 1'b0, 1'b1, 1'b1, 1'b1, 4'hf, 4'hf, 4'hf);

        // Random mix of per-bit controls.
        for (int k = 0; k < 24; k++) begin
            r3 = 3'($urandom_range(0, 7));
            step($sformatf("rand_%0d", k), ($urandom_range(0, 9) == 0),
                 r3[2], r3[1], r3[0],
                 4'($urandom), 4'($urandom), 4'($urandom));
        end

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
